// File: rtl/sonar_sweep_ctrl.sv
// sonar_sweep_ctrl - sweep sequencer for the sonar top level.
// Steps the servo through N_POS positions (wrap or ping-pong order). At each
// position it waits SETTLE cycles, fires a distance measurement with up to
// MAX_RETRY retries on echo timeout, then sends an N_CHARS-character frame
// through the UART transmitter one character at a time.
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   ligar          run enable (level)
//   modo           0 = wrap sweep, 1 = ping-pong sweep
//   pronto_medida  measurement complete pulse
//   pronto_tx      character transmitted pulse
//   medir          start-measurement pulse
//   partida_serial start-transmission pulse for char_idx
//   char_idx       frame character index
//   posicao        current servo position
//   direcao        0 = ascending, 1 = descending
//   falha          frame carries a measurement that exhausted its retries
//   fim_posicao    position finished pulse
//   db_estado      current state code
module sonar_sweep_ctrl #(
    parameter int N_POS     = 8,
    parameter int POS_W     = 3,
    parameter int SETTLE    = 100_000_000,
    parameter int TIMEOUT   = 2_000_000,
    parameter int MAX_RETRY = 2,
    parameter int N_CHARS   = 8,
    parameter int CW        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             modo,
    input  logic             pronto_medida,
    input  logic             pronto_tx,
    output logic             medir,
    output logic             partida_serial,
    output logic [CW-1:0]    char_idx,
    output logic [POS_W-1:0] posicao,
    output logic             direcao,
    output logic             falha,
    output logic             fim_posicao,
    output logic [3:0]       db_estado
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        INICIAL        = 3'd0,
        PREPARA        = 3'd1,
        ESPERA_POS     = 3'd2,
        MEDE           = 3'd3,
        AGUARDA_MEDIDA = 3'd4,
        TRANSMITE      = 3'd5,
        AGUARDA_TX     = 3'd6,
        FIM_POSICAO    = 3'd7
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [SW-1:0]      settle_cnt_r;
    logic [TW-1:0]      tmo_cnt_r;
    logic [RW-1:0]      retry_r;
    logic [CW-1:0]      char_idx_r;
    logic [POS_W-1:0]   posicao_r;
    logic               direcao_r;
    logic               falha_r;
    logic [POS_W-1:0]   pos_next_s;
    logic               dir_next_s;
    logic               medir_s;
    logic               partida_s;
    logic               fim_s;

    logic settle_done_s;
    logic tmo_last_s;
    logic retry_left_s;
    logic char_last_s;
    logic pos_last_s;
    logic pos_first_s;

    assign settle_done_s = (settle_cnt_r == SW'(SETTLE - 1));
    assign tmo_last_s    = (tmo_cnt_r == TW'(TIMEOUT - 1));
    assign retry_left_s  = (retry_r < RW'(MAX_RETRY));
    assign char_last_s   = (char_idx_r == CW'(N_CHARS - 1));
    assign pos_last_s    = (posicao_r == POS_W'(N_POS - 1));
    assign pos_first_s   = (posicao_r == POS_W'(0));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; ligar only matters in the idle, settle and end-of-position states
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INICIAL: begin
                if (ligar) state_next_s = PREPARA;
                else       state_next_s = INICIAL;
            end
            PREPARA: state_next_s = ESPERA_POS;
            ESPERA_POS: begin
                if (!ligar)             state_next_s = INICIAL;
                else if (settle_done_s) state_next_s = MEDE;
                else                    state_next_s = ESPERA_POS;
            end
            MEDE: state_next_s = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                // A completed measurement beats a simultaneous timeout
                if (pronto_medida)   state_next_s = TRANSMITE;
                else if (tmo_last_s) state_next_s = retry_left_s ? MEDE : TRANSMITE;
                else                 state_next_s = AGUARDA_MEDIDA;
            end
            TRANSMITE: state_next_s = AGUARDA_TX;
            AGUARDA_TX: begin
                if (pronto_tx) state_next_s = char_last_s ? FIM_POSICAO : TRANSMITE;
                else           state_next_s = AGUARDA_TX;
            end
            FIM_POSICAO: begin
                if (ligar) state_next_s = ESPERA_POS;
                else       state_next_s = INICIAL;
            end
            default: state_next_s = INICIAL;
        endcase
    end

    // Moore pulse decode from the state register
    always_comb begin
        medir_s   = 1'b0;
        partida_s = 1'b0;
        fim_s     = 1'b0;
        case (state_r)
            MEDE:        medir_s   = 1'b1;
            TRANSMITE:   partida_s = 1'b1;
            FIM_POSICAO: fim_s     = 1'b1;
            default:     medir_s   = 1'b0;
        endcase
    end

    // Next servo position; descending only exists in ping-pong mode
    always_comb begin
        pos_next_s = posicao_r;
        dir_next_s = direcao_r;
        if (!modo) begin
            dir_next_s = 1'b0;
            if (pos_last_s) pos_next_s = POS_W'(0);
            else            pos_next_s = posicao_r + POS_W'(1);
        end else if (!direcao_r) begin
            if (pos_last_s) begin
                dir_next_s = 1'b1;
                pos_next_s = posicao_r - POS_W'(1);
            end else begin
                pos_next_s = posicao_r + POS_W'(1);
            end
        end else begin
            if (pos_first_s) begin
                dir_next_s = 1'b0;
                pos_next_s = posicao_r + POS_W'(1);
            end else begin
                pos_next_s = posicao_r - POS_W'(1);
            end
        end
    end

    // Datapath registers: counters, retry, frame index, position and fault flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt_r <= '0;
            tmo_cnt_r    <= '0;
            retry_r      <= '0;
            char_idx_r   <= '0;
            posicao_r    <= '0;
            direcao_r    <= 1'b0;
            falha_r      <= 1'b0;
        end else begin
            case (state_r)
                PREPARA: begin
                    posicao_r    <= '0;
                    direcao_r    <= 1'b0;
                    char_idx_r   <= '0;
                    retry_r      <= '0;
                    settle_cnt_r <= '0;
                    falha_r      <= 1'b0;
                end
                ESPERA_POS: settle_cnt_r <= settle_cnt_r + SW'(1);
                MEDE:       tmo_cnt_r    <= '0;
                AGUARDA_MEDIDA: begin
                    tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    if (pronto_medida) begin
                        falha_r <= 1'b0;
                    end else if (tmo_last_s) begin
                        if (retry_left_s) retry_r <= retry_r + RW'(1);
                        else              falha_r <= 1'b1;
                    end else begin
                        falha_r <= falha_r;
                    end
                end
                AGUARDA_TX: begin
                    if (pronto_tx && !char_last_s) char_idx_r <= char_idx_r + CW'(1);
                    else                           char_idx_r <= char_idx_r;
                end
                FIM_POSICAO: begin
                    // falha was visible for the whole frame and this cycle; drop it now
                    char_idx_r   <= '0;
                    retry_r      <= '0;
                    settle_cnt_r <= '0;
                    falha_r      <= 1'b0;
                    posicao_r    <= pos_next_s;
                    direcao_r    <= dir_next_s;
                end
                default: tmo_cnt_r <= tmo_cnt_r;
            endcase
        end
    end

    assign medir          = medir_s;
    assign partida_serial = partida_s;
    assign fim_posicao    = fim_s;
    assign char_idx       = char_idx_r;
    assign posicao        = posicao_r;
    assign direcao        = direcao_r;
    assign falha          = falha_r;
    assign db_estado      = {1'b0, state_r};

endmodule

// File: tb/tb_sonar_sweep_ctrl.sv
module tb_sonar_sweep_ctrl;

    localparam int SETTLE  = 4;
    localparam int N_CHARS = 3;

    logic       clock;
    logic       reset;
    logic       ligar;
    logic       modo;
    logic       pronto_medida;
    logic       pronto_tx;
    logic       medir;
    logic       partida_serial;
    logic [1:0] char_idx;
    logic [1:0] posicao;
    logic       direcao;
    logic       falha;
    logic       fim_posicao;
    logic [3:0] db_estado;

    sonar_sweep_ctrl #(
        .N_POS(4), .POS_W(2), .SETTLE(SETTLE), .TIMEOUT(10),
        .MAX_RETRY(1), .N_CHARS(N_CHARS), .CW(2)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
        .pronto_medida(pronto_medida), .pronto_tx(pronto_tx),
        .medir(medir), .partida_serial(partida_serial), .char_idx(char_idx),
        .posicao(posicao), .direcao(direcao), .falha(falha),
        .fim_posicao(fim_posicao), .db_estado(db_estado)
    );

    typedef struct {
        logic [1:0] idx;
        logic [1:0] pos;
        logic       dir;
        logic       fal;
    } tx_t;

    typedef struct {
        logic [1:0] pos;
        logic       dir;
        logic       fal;
    } fim_t;

    tx_t  exp_tx[$];
    fim_t exp_fim[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int medir_cnt = 0;
    int first_medir = 0;
    int last_medir = 0;
    int fim_cnt = 0;
    int echo_delay = 0;
    int echo_skip = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Pushes the expected frame and end-of-position record for one position
    task automatic push_pos(input logic [1:0] p, input logic d, input logic f);
        tx_t  t;
        fim_t e;
        for (int i = 0; i < N_CHARS; i++) begin
            t.idx = 2'(i);
            t.pos = p;
            t.dir = d;
            t.fal = f;
            exp_tx.push_back(t);
        end
        e.pos = p;
        e.dir = d;
        e.fal = f;
        exp_fim.push_back(e);
    endtask

    task automatic wait_fim(input int target, input int budget);
        int n;
        n = 0;
        while (fim_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("fim_reached", 32'(fim_cnt >= target), 32'd1);
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n;
        n = 0;
        while (db_estado !== st && n < budget) begin
            step();
            n++;
        end
        chk("state_reached", 32'(db_estado), 32'(st));
    endtask

    // Environment: echo and UART responders
    initial begin
        int m_pend;
        int t_pend;
        m_pend = 0;
        t_pend = 0;
        pronto_medida = 1'b0;
        pronto_tx = 1'b0;
        forever begin
            @(negedge clock);
            pronto_medida = 1'b0;
            pronto_tx = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) pronto_medida = 1'b1;
            end
            if (t_pend > 0) begin
                t_pend--;
                if (t_pend == 0) pronto_tx = 1'b1;
            end
            if (medir === 1'b1) begin
                if (echo_skip > 0) echo_skip--;
                else if (echo_delay > 0) m_pend = echo_delay;
            end
            if (partida_serial === 1'b1) t_pend = 2;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT emits a pulse
    initial forever begin
        tx_t  t;
        fim_t e;
        @(negedge clock);
        if (medir === 1'b1) begin
            if (medir_cnt == 0) first_medir = cyc;
            last_medir = cyc;
            medir_cnt++;
        end
        if (partida_serial === 1'b1) begin
            chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) begin
                t = exp_tx.pop_front();
                chk("tx_char_idx", 32'(char_idx), 32'(t.idx));
                chk("tx_posicao", 32'(posicao), 32'(t.pos));
                chk("tx_direcao", 32'(direcao), 32'(t.dir));
                chk("tx_falha", 32'(falha), 32'(t.fal));
            end
        end
        if (fim_posicao === 1'b1) begin
            fim_cnt++;
            chk("fim_expected", 32'(exp_fim.size() != 0), 32'd1);
            if (exp_fim.size() != 0) begin
                e = exp_fim.pop_front();
                chk("fim_posicao_val", 32'(posicao), 32'(e.pos));
                chk("fim_direcao", 32'(direcao), 32'(e.dir));
                chk("fim_falha", 32'(falha), 32'(e.fal));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int tgt;
        logic [1:0] seq_pos [8];
        logic       seq_dir [8];

        reset = 1'b0;
        ligar = 1'b0;
        modo  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_db_estado", 32'(db_estado), 32'd0);
        chk("rst_posicao", 32'(posicao), 32'd0);
        chk("rst_pulses", 32'({medir, partida_serial, fim_posicao}), 32'd0);
        chk("rst_falha", 32'(falha), 32'd0);
        reset = 1'b1;
        step();
        chk("idle_db_estado", 32'(db_estado), 32'd0);

        // 1. Nominal position
        echo_delay = 3;
        medir_cnt = 0;
        push_pos(2'd0, 1'b0, 1'b0);
        tgt = fim_cnt + 1;
        ligar = 1'b1;
        k = cyc + 1;
        wait_fim(tgt, 200);
        chk("t1_medir_cnt", 32'(medir_cnt), 32'd1);
        chk("t1_medir_cycle", 32'(first_medir), 32'(k + SETTLE + 1));
        step();
        chk("t1_next_state", 32'(db_estado), 32'd2);
        chk("t1_posicao", 32'(posicao), 32'd1);
        chk("t1_falha", 32'(falha), 32'd0);
        ligar = 1'b0;
        step();
        chk("t1_idle", 32'(db_estado), 32'd0);

        // 2. Echo timeout on every attempt
        echo_delay = 0;
        medir_cnt = 0;
        push_pos(2'd0, 1'b0, 1'b1);
        tgt = fim_cnt + 1;
        ligar = 1'b1;
        wait_fim(tgt, 300);
        chk("t2_medir_cnt", 32'(medir_cnt), 32'd2);
        chk("t2_medir_gap", 32'(last_medir - first_medir), 32'd11);
        step();
        chk("t2_next_state", 32'(db_estado), 32'd2);
        chk("t2_falha_clear", 32'(falha), 32'd0);
        ligar = 1'b0;
        step();

        // 3a. Wrap sweep
        echo_delay = 3;
        seq_pos = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 8; i++) push_pos(seq_pos[i], 1'b0, 1'b0);
        tgt = fim_cnt + 8;
        modo = 1'b0;
        ligar = 1'b1;
        wait_fim(tgt, 1000);
        ligar = 1'b0;
        step();
        chk("t3a_idle", 32'(db_estado), 32'd0);

        // 3b. Ping-pong sweep
        seq_pos = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        seq_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) push_pos(seq_pos[i], seq_dir[i], 1'b0);
        tgt = fim_cnt + 8;
        modo = 1'b1;
        ligar = 1'b1;
        wait_fim(tgt, 1000);
        ligar = 1'b0;
        step();
        chk("t3b_idle", 32'(db_estado), 32'd0);
        chk("t3b_posicao", 32'(posicao), 32'd2);
        modo = 1'b0;

        // 4. Disable during measurement wait
        medir_cnt = 0;
        push_pos(2'd0, 1'b0, 1'b0);
        tgt = fim_cnt + 1;
        ligar = 1'b1;
        wait_state(4'd4, 50);
        ligar = 1'b0;
        wait_fim(tgt, 200);
        step();
        chk("t4_idle", 32'(db_estado), 32'd0);
        chk("t4_posicao", 32'(posicao), 32'd1);
        for (int i = 0; i < 20; i++) step();
        chk("t4_no_medir", 32'(medir_cnt), 32'd1);
        chk("t4_posicao_held", 32'(posicao), 32'd1);

        // 5. Echo arrives exactly in the final timeout cycle
        medir_cnt = 0;
        echo_skip = 1;
        echo_delay = 10;
        push_pos(2'd0, 1'b0, 1'b0);
        tgt = fim_cnt + 1;
        ligar = 1'b1;
        wait_fim(tgt, 300);
        ligar = 1'b0;
        chk("t5_medir_cnt", 32'(medir_cnt), 32'd2);
        step();
        chk("t5_idle", 32'(db_estado), 32'd0);
        chk("t5_queue_empty", 32'(exp_tx.size() + exp_fim.size()), 32'd0);

        // 6. Asynchronous reset while a faulty frame is in flight
        echo_delay = 3;
        push_pos(2'd0, 1'b0, 1'b0);
        push_pos(2'd1, 1'b0, 1'b1);
        tgt = fim_cnt + 1;
        ligar = 1'b1;
        wait_fim(tgt, 200);
        echo_delay = 0;
        begin
            int n;
            n = 0;
            while (!(db_estado === 4'd6 && char_idx === 2'd1 && posicao === 2'd1) && n < 300) begin
                step();
                n++;
            end
        end
        chk("t6_pre_state", 32'(db_estado), 32'd6);
        chk("t6_pre_falha", 32'(falha), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_db_estado", 32'(db_estado), 32'd0);
        chk("t6_posicao", 32'(posicao), 32'd0);
        chk("t6_char_idx", 32'(char_idx), 32'd0);
        chk("t6_falha", 32'(falha), 32'd0);
        chk("t6_pulses", 32'({medir, partida_serial, fim_posicao}), 32'd0);
        exp_tx.delete();
        exp_fim.delete();
        ligar = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("t6_after_release", 32'(db_estado), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
